// File: rtl/machine_trap_ctrl_pkg.sv
// Shared types and constants for the M-mode trap entry/return sequencer.
package machine_trap_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_RESET       = 2'd0,
        ST_OPERATING   = 2'd1,
        ST_TRAP_TAKEN  = 2'd2,
        ST_TRAP_RETURN = 2'd3
    } trap_state_e;

    // Exception cause codes
    localparam int unsigned EXC_MISALIGN = 0;
    localparam int unsigned EXC_ILLEGAL  = 2;
    localparam int unsigned EXC_BREAK    = 3;
    localparam int unsigned EXC_ECALL_M  = 11;

    // Interrupt cause codes
    localparam int unsigned IRQ_TIMER    = 7;
    localparam int unsigned IRQ_EXT      = 11;

    // mtvec[1:0] mode encodings; the reserved encodings behave as direct
    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    // Clears the two low bits of an address (mtvec base, mepc target)
    localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

    // Trap handler address: base, plus 4*cause for interrupts in vectored mode
    function automatic logic [31:0] trap_target(
        input logic [31:0] mtvec,
        input logic        is_int,
        input logic [31:0] cause
    );
        logic [31:0] base;
        logic [31:0] tgt;
        base = mtvec & ADDR_ALIGN_MASK;
        case (mtvec[1:0])
            MTVEC_DIRECT:   tgt = base;
            MTVEC_VECTORED: tgt = is_int ? (base + (cause << 2)) : base;
            default:        tgt = base;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/machine_trap_ctrl_priority_enc.sv
// Combinational trap priority encoder: event vector -> valid, interrupt flag, cause.
module trap_priority_enc
    import machine_trap_ctrl_pkg::*;
#(
    parameter int unsigned CAUSE_W = 4
) (
    input  logic               i_misaligned,
    input  logic               i_illegal,
    input  logic               i_ebreak,
    input  logic               i_ecall,
    input  logic               i_meip,
    input  logic               i_mtip,
    input  logic               i_mie,
    input  logic               i_meie,
    input  logic               i_mtie,
    output logic               o_valid,
    output logic               o_is_int,
    output logic [CAUSE_W-1:0] o_cause
);

    logic w_ext_irq;
    logic w_tmr_irq;

    assign w_ext_irq = i_meip & i_mie & i_meie;
    assign w_tmr_irq = i_mtip & i_mie & i_mtie;

    // Exceptions first in fixed order, then enabled interrupts
    always_comb begin
        o_valid  = 1'b1;
        o_is_int = 1'b0;
        o_cause  = '0;
        if (i_misaligned) begin
            o_cause = CAUSE_W'(EXC_MISALIGN);
        end else if (i_illegal) begin
            o_cause = CAUSE_W'(EXC_ILLEGAL);
        end else if (i_ebreak) begin
            o_cause = CAUSE_W'(EXC_BREAK);
        end else if (i_ecall) begin
            o_cause = CAUSE_W'(EXC_ECALL_M);
        end else if (w_ext_irq) begin
            o_is_int = 1'b1;
            o_cause  = CAUSE_W'(IRQ_EXT);
        end else if (w_tmr_irq) begin
            o_is_int = 1'b1;
            o_cause  = CAUSE_W'(IRQ_TIMER);
        end else begin
            o_valid = 1'b0;
        end
    end

endmodule

// File: rtl/machine_trap_ctrl.sv
// M-mode trap entry/return sequencer between execute and the CSR file.
module machine_trap_ctrl
    import machine_trap_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned CAUSE_W      = 4
) (
    input  logic               clock,
    input  logic               rst_n_in,
    input  logic [31:0]        pc_in,
    input  logic               misaligned_in,
    input  logic               illegal_in,
    input  logic               ebreak_in,
    input  logic               ecall_in,
    input  logic               mret_in,
    input  logic               meip_in,
    input  logic               mtip_in,
    input  logic               mie_in,
    input  logic               meie_in,
    input  logic               mtie_in,
    input  logic [31:0]        mtvec_in,
    input  logic [31:0]        epc_in,
    output logic               set_epc_out,
    output logic [31:0]        trap_pc_out,
    output logic               set_cause_out,
    output logic               int_out,
    output logic [CAUSE_W-1:0] cause_out,
    output logic               mie_clear_out,
    output logic               mie_set_out,
    output logic               redirect_out,
    output logic [31:0]        redirect_addr_out,
    output logic               busy_out
);

    trap_state_e        r_state;
    logic               r_set_epc;
    logic [31:0]        r_trap_pc;
    logic               r_set_cause;
    logic               r_int;
    logic [CAUSE_W-1:0] r_cause;
    logic               r_mie_clear;
    logic               r_mie_set;
    logic               r_redirect;
    logic [31:0]        r_redirect_addr;
    logic               r_busy;

    logic               w_trap_valid;
    logic               w_trap_int;
    logic [CAUSE_W-1:0] w_trap_cause;
    logic [31:0]        w_trap_target;

    trap_priority_enc #(
        .CAUSE_W (CAUSE_W)
    ) u_prio (
        .i_misaligned (misaligned_in),
        .i_illegal    (illegal_in),
        .i_ebreak     (ebreak_in),
        .i_ecall      (ecall_in),
        .i_meip       (meip_in),
        .i_mtip       (mtip_in),
        .i_mie        (mie_in),
        .i_meie       (meie_in),
        .i_mtie       (mtie_in),
        .o_valid      (w_trap_valid),
        .o_is_int     (w_trap_int),
        .o_cause      (w_trap_cause)
    );

    assign w_trap_target = trap_target(mtvec_in, w_trap_int, 32'(w_trap_cause));

    // Sequencer state and registered outputs; pulses default low each cycle
    always_ff @(posedge clock) begin
        if (!rst_n_in) begin
            r_state         <= ST_RESET;
            r_set_epc       <= 1'b0;
            r_trap_pc       <= '0;
            r_set_cause     <= 1'b0;
            r_int           <= 1'b0;
            r_cause         <= '0;
            r_mie_clear     <= 1'b0;
            r_mie_set       <= 1'b0;
            r_redirect      <= 1'b0;
            r_redirect_addr <= '0;
            r_busy          <= 1'b0;
        end else begin
            r_set_epc   <= 1'b0;
            r_set_cause <= 1'b0;
            r_mie_clear <= 1'b0;
            r_mie_set   <= 1'b0;
            r_redirect  <= 1'b0;
            r_busy      <= 1'b0;
            case (r_state)
                ST_RESET: begin
                    r_state         <= ST_OPERATING;
                    r_redirect      <= 1'b1;
                    r_redirect_addr <= RESET_VECTOR;
                end
                ST_OPERATING: begin
                    if (w_trap_valid) begin
                        r_state         <= ST_TRAP_TAKEN;
                        r_set_epc       <= 1'b1;
                        r_trap_pc       <= pc_in;
                        r_set_cause     <= 1'b1;
                        r_int           <= w_trap_int;
                        r_cause         <= w_trap_cause;
                        r_mie_clear     <= 1'b1;
                        r_redirect      <= 1'b1;
                        r_redirect_addr <= w_trap_target;
                        r_busy          <= 1'b1;
                    end else if (mret_in) begin
                        r_state         <= ST_TRAP_RETURN;
                        r_mie_set       <= 1'b1;
                        r_redirect      <= 1'b1;
                        r_redirect_addr <= epc_in & ADDR_ALIGN_MASK;
                        r_busy          <= 1'b1;
                    end
                end
                default: begin
                    // Pulse cycle of a trap or return; new events are ignored here
                    r_state <= ST_OPERATING;
                end
            endcase
        end
    end

    assign set_epc_out       = r_set_epc;
    assign trap_pc_out       = r_trap_pc;
    assign set_cause_out     = r_set_cause;
    assign int_out           = r_int;
    assign cause_out         = r_cause;
    assign mie_clear_out     = r_mie_clear;
    assign mie_set_out       = r_mie_set;
    assign redirect_out      = r_redirect;
    assign redirect_addr_out = r_redirect_addr;
    assign busy_out          = r_busy;

endmodule

// File: tb/tb_machine_trap_ctrl.sv
// Scoreboard bench for machine_trap_ctrl: driver predicts pulses, negedge monitor checks them.
module tb_machine_trap_ctrl;

    localparam logic [31:0] RV = 32'h0000_0080;

    logic        clock;
    logic        rst_n_in;
    logic [31:0] pc_in;
    logic        misaligned_in, illegal_in, ebreak_in, ecall_in, mret_in;
    logic        meip_in, mtip_in, mie_in, meie_in, mtie_in;
    logic [31:0] mtvec_in, epc_in;
    logic        set_epc_out, set_cause_out, int_out, mie_clear_out, mie_set_out;
    logic        redirect_out, busy_out;
    logic [31:0] trap_pc_out, redirect_addr_out;
    logic [3:0]  cause_out;

    machine_trap_ctrl #(.RESET_VECTOR(RV), .CAUSE_W(4)) dut (
        .clock(clock), .rst_n_in(rst_n_in), .pc_in(pc_in),
        .misaligned_in(misaligned_in), .illegal_in(illegal_in), .ebreak_in(ebreak_in),
        .ecall_in(ecall_in), .mret_in(mret_in), .meip_in(meip_in), .mtip_in(mtip_in),
        .mie_in(mie_in), .meie_in(meie_in), .mtie_in(mtie_in),
        .mtvec_in(mtvec_in), .epc_in(epc_in),
        .set_epc_out(set_epc_out), .trap_pc_out(trap_pc_out),
        .set_cause_out(set_cause_out), .int_out(int_out), .cause_out(cause_out),
        .mie_clear_out(mie_clear_out), .mie_set_out(mie_set_out),
        .redirect_out(redirect_out), .redirect_addr_out(redirect_addr_out),
        .busy_out(busy_out)
    );

    typedef struct {
        int          cyc;
        bit          set_epc;
        logic [31:0] trap_pc;
        bit          set_cause;
        bit          intr;
        logic [3:0]  cause;
        bit          mie_clear;
        bit          mie_set;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rst_at_edge = 1'b1;

    // Reference model state: pending reset redirect, and cycles during which events are ignored
    bit   m_after_reset = 1'b1;
    int   m_cooldown = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc = cyc + 1;
        rst_at_edge = rst_n_in;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    // Predict the DUT response to the edge that will sample the current inputs
    task automatic model_predict();
        exp_t e;
        bit   cond [6];
        int   code [6];
        bit   isint[6];
        int   hit;
        cond  = '{misaligned_in, illegal_in, ebreak_in, ecall_in,
                  meip_in & mie_in & meie_in, mtip_in & mie_in & mtie_in};
        code  = '{0, 2, 3, 11, 11, 7};
        isint = '{0, 0, 0, 0, 1, 1};
        e = '{cyc: cyc + 1, set_epc: 0, trap_pc: 0, set_cause: 0, intr: 0,
              cause: 0, mie_clear: 0, mie_set: 0, addr: 0};
        if (!rst_n_in) begin
            m_after_reset = 1'b1;
            m_cooldown = 0;
        end else if (m_after_reset) begin
            m_after_reset = 1'b0;
            e.addr = RV;
            exp_q.push_back(e);
        end else if (m_cooldown > 0) begin
            m_cooldown = m_cooldown - 1;
        end else begin
            hit = -1;
            for (int i = 5; i >= 0; i--) if (cond[i]) hit = i;
            if (hit >= 0) begin
                e.set_epc   = 1; e.trap_pc = pc_in;
                e.set_cause = 1; e.intr = isint[hit]; e.cause = 4'(code[hit]);
                e.mie_clear = 1;
                e.addr = (mtvec_in - (mtvec_in % 4)) +
                         ((mtvec_in % 4 == 1 && isint[hit]) ? 32'(code[hit] * 4) : 32'd0);
                exp_q.push_back(e);
                m_cooldown = 1;
            end else if (mret_in) begin
                e.mie_set = 1;
                e.addr = epc_in - (epc_in % 4);
                exp_q.push_back(e);
                m_cooldown = 1;
            end
        end
    endtask

    task automatic step();
        model_predict();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_events();
        misaligned_in = 0; illegal_in = 0; ebreak_in = 0; ecall_in = 0; mret_in = 0;
        meip_in = 0; mtip_in = 0;
    endtask

    // Monitor: compares every redirect cycle against the scoreboard, quiet cycles against zero
    always @(negedge clock) begin
        exp_t e;
        if (!rst_at_edge) begin
            chk("reset_outputs_zero",
                {22'd0, set_epc_out, set_cause_out, int_out, cause_out, mie_clear_out,
                 mie_set_out, redirect_out, busy_out}, 32'd0);
            chk("reset_trap_pc", trap_pc_out, 32'd0);
            chk("reset_redirect_addr", redirect_addr_out, 32'd0);
        end else if (redirect_out) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_redirect", redirect_addr_out, 32'hDEAD_DEAD);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                chk("set_epc", 32'(set_epc_out), 32'(e.set_epc));
                if (e.set_epc) chk("trap_pc", trap_pc_out, e.trap_pc);
                chk("set_cause", 32'(set_cause_out), 32'(e.set_cause));
                if (e.set_cause) begin
                    chk("int", 32'(int_out), 32'(e.intr));
                    chk("cause", 32'(cause_out), 32'(e.cause));
                end
                chk("mie_clear", 32'(mie_clear_out), 32'(e.mie_clear));
                chk("mie_set", 32'(mie_set_out), 32'(e.mie_set));
                chk("redirect_addr", redirect_addr_out, e.addr);
                chk("busy", 32'(busy_out), 32'(e.set_epc | e.mie_set));
            end
        end else begin
            chk("idle_quiet", {27'd0, set_epc_out, set_cause_out, mie_clear_out,
                               mie_set_out, busy_out}, 32'd0);
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                chk("missed_pulse", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        rst_n_in = 0; pc_in = 0; mtvec_in = 0; epc_in = 0;
        mie_in = 0; meie_in = 0; mtie_in = 0;
        clear_events();

        // Reset held, then release: reset-vector redirect, then idle
        step(); step(); step();
        rst_n_in = 1;
        step(); step(); step();

        // Illegal instruction, direct mtvec
        pc_in = 32'h100; mtvec_in = 32'h200; illegal_in = 1;
        step(); clear_events(); step(); step();

        // Vectored external interrupt
        mtvec_in = 32'h301; mie_in = 1; meie_in = 1; meip_in = 1; pc_in = 32'h480;
        step(); clear_events(); step(); step();

        // Masked timer irq stays silent, then enabling it traps
        mtie_in = 0; mtip_in = 1; mtvec_in = 32'h200;
        step(); step(); step();
        mtie_in = 1;
        step(); mtip_in = 0; step(); step();

        // MRET with misaligned mepc
        epc_in = 32'h1237; mret_in = 1;
        step(); clear_events(); step(); step();

        // Exception beats irq and mret; vectored mode does not offset exceptions
        mtvec_in = 32'h301; ebreak_in = 1; ecall_in = 1; meip_in = 1; mret_in = 1; pc_in = 32'h44;
        step(); clear_events(); step(); step();

        // Vectored wrap past 2^32, and reserved mode 11 acts as direct
        mtvec_in = 32'hFFFF_FFF1; mtip_in = 1; mtie_in = 1; meie_in = 0;
        step(); clear_events(); step(); step();
        mtvec_in = 32'h0000_0503; meie_in = 1; meip_in = 1;
        step(); clear_events(); step(); step();

        // Misaligned fetch outranks everything
        misaligned_in = 1; illegal_in = 1; pc_in = 32'h7;
        step(); clear_events(); step(); step();

        // ECALL + MRET, reset during the trap pulse cycle
        mtvec_in = 32'h400; ecall_in = 1; mret_in = 1; pc_in = 32'h900;
        step(); clear_events();
        rst_n_in = 0;
        step(); step();
        rst_n_in = 1;
        step(); step(); step();

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n_in      = ($urandom_range(0, 199) != 0);
            pc_in         = $urandom;
            epc_in        = $urandom;
            mtvec_in      = $urandom;
            misaligned_in = ($urandom_range(0, 15) == 0);
            illegal_in    = ($urandom_range(0, 11) == 0);
            ebreak_in     = ($urandom_range(0, 11) == 0);
            ecall_in      = ($urandom_range(0, 11) == 0);
            mret_in       = ($urandom_range(0, 5) == 0);
            meip_in       = ($urandom_range(0, 3) == 0);
            mtip_in       = ($urandom_range(0, 3) == 0);
            mie_in        = 1'($urandom_range(0, 1));
            meie_in       = 1'($urandom_range(0, 1));
            mtie_in       = 1'($urandom_range(0, 1));
            step();
        end

        rst_n_in = 1;
        clear_events();
        for (int n = 0; n < 6; n++) step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
